fetch_queue: RTL and testbench

//  Parametrised decoupling FIFO of fetch bundles between icache output and predecode input.

---
 rtl/fetch_queue.sv | 114 +++++++++++
 tb/tb_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Decoupling FIFO of fetch bundles between the icache output   |
// |               and predecode. Each entry holds FETCH_W instructions, the    |
// |               bundle PC, fetch exception info and BTB prediction metadata. |
// |               A frontend flush empties it so a redirect refills cleanly.   |
// |               Optional macro FQ_BYPASS_EN adds an empty-queue combinational |
// |               enq->deq bypass.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int FETCH_W   = 2,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                         cpu_clock_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         enq_valid_i,
  output logic                         enq_busy_o,
  input  logic [32*FETCH_W-1:0]        enq_instr_i,
  input  logic [31:0]                  enq_pc_i,
  input  logic                         enq_excp_vld_i,
  input  logic [3:0]                   enq_excp_code_i,
  input  logic [38:0]                  enq_btb_i,
  output logic                         deq_valid_o,
  input  logic                         deq_busy_i,
  output logic [32*FETCH_W-1:0]        deq_instr_o,
  output logic [31:0]                  deq_pc_o,
  output logic                         deq_excp_vld_o,
  output logic [3:0]                   deq_excp_code_o,
  output logic [38:0]                  deq_btb_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int INSTR_W = 32 * FETCH_W;
  localparam int ENTRY_W = INSTR_W + 32 + 1 + 4 + 39;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_COUNT   = CNT_W'(AF_THRESH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               bypass;
  logic               enq_fire;
  logic               deq_fire;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] enq_entry;
  logic [ENTRY_W-1:0] deq_entry;

  assign enq_entry = {enq_instr_i, enq_pc_i, enq_excp_vld_i, enq_excp_code_i, enq_btb_i};
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);

`ifdef FQ_BYPASS_EN
  // Only an empty queue may forward the incoming bundle, so ordering is preserved.
  assign bypass = empty & enq_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Busy is a pure decode of held state; the consumer's stall never reaches it.
  assign enq_busy_o  = full;
  assign deq_valid_o = (~empty | bypass) & ~flush_i;
  assign deq_entry   = bypass ? enq_entry : mem[rd_ptr];
  assign {deq_instr_o, deq_pc_o, deq_excp_vld_o, deq_excp_code_o, deq_btb_o} = deq_entry;

  assign enq_fire = enq_valid_i & ~full & ~flush_i;
  assign deq_fire = deq_valid_o & ~deq_busy_i;
  // A bypassed bundle taken by the consumer never touches storage.
  assign push     = enq_fire & ~(bypass & ~deq_busy_i);
  assign pop      = deq_fire & ~bypass;

  assign count_o       = count;
  assign almost_full_o = (count >= AF_COUNT);

  // Payload storage; intentionally not reset, contents are don't-care while empty.
  always_ff @(posedge cpu_clock_i) begin
    if (push) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // Pointers and occupancy; reset and flush both discard everything held.
  always_ff @(posedge cpu_clock_i) begin
    if (reset_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Self-checking bench for fetch_queue against a queue model.   |
// |               Honours FQ_BYPASS_EN when the design is built with it.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int FW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  typedef struct packed {
    logic [32*FW-1:0] instr;
    logic [31:0]      pc;
    logic             ev;
    logic [3:0]       code;
    logic [38:0]      btb;
  } bundle_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic             enq_busy;
  logic [32*FW-1:0] enq_instr;
  logic [31:0]      enq_pc;
  logic             enq_excp_vld;
  logic [3:0]       enq_excp_code;
  logic [38:0]      enq_btb;
  logic             deq_valid;
  logic             deq_busy;
  logic [32*FW-1:0] deq_instr;
  logic [31:0]      deq_pc;
  logic             deq_excp_vld;
  logic [3:0]       deq_excp_code;
  logic [38:0]      deq_btb;
  logic [2:0]       count;
  logic             almost_full;

  always #5 clk = ~clk;

  fetch_queue #(.FETCH_W(FW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .cpu_clock_i     (clk),
    .reset_i         (rst),
    .flush_i         (flush),
    .enq_valid_i     (enq_valid),
    .enq_busy_o      (enq_busy),
    .enq_instr_i     (enq_instr),
    .enq_pc_i        (enq_pc),
    .enq_excp_vld_i  (enq_excp_vld),
    .enq_excp_code_i (enq_excp_code),
    .enq_btb_i       (enq_btb),
    .deq_valid_o     (deq_valid),
    .deq_busy_i      (deq_busy),
    .deq_instr_o     (deq_instr),
    .deq_pc_o        (deq_pc),
    .deq_excp_vld_o  (deq_excp_vld),
    .deq_excp_code_o (deq_excp_code),
    .deq_btb_o       (deq_btb),
    .count_o         (count),
    .almost_full_o   (almost_full)
  );

  bundle_t     mdl[$];
  bundle_t     src;
  logic [31:0] next_pc;
  int          checks   = 0;
  int          failures = 0;
  logic        obs_valid;
  logic        obs_busy;
  logic        obs_af;
  logic [2:0]  obs_count;
  logic [31:0] obs_pc;
  logic        accepted;

  // Compare one observed value against the bench's expectation.
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [31:0] pc);
    bundle_t b;
    b.instr = {$urandom, $urandom};
    b.pc    = pc;
    b.ev    = 1'($urandom_range(0, 1));
    b.code  = 4'($urandom);
    b.btb   = {7'($urandom), $urandom};
    return b;
  endfunction

  task automatic load_src(input logic [31:0] pc);
    src     = mk(pc);
    next_pc = pc + 32'd8;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic ev, input logic db, input logic fl, input logic rs);
    bundle_t exp_b;
    logic    exp_valid;
    logic    byp;
    logic    efire;
    logic    dfire;
    int      n;
    @(negedge clk);
    rst       = rs;
    flush     = fl;
    enq_valid = ev;
    deq_busy  = db;
    {enq_instr, enq_pc, enq_excp_vld, enq_excp_code, enq_btb} = src;
    #1;
    n   = mdl.size();
    byp = 1'b0;
`ifdef FQ_BYPASS_EN
    byp = (n == 0) && ev && !fl;
`endif
    exp_valid = ((n != 0) || byp) && !fl;
    exp_b     = (byp || n == 0) ? src : mdl[0];
    obs_valid = deq_valid;
    obs_busy  = enq_busy;
    obs_af    = almost_full;
    obs_count = count;
    obs_pc    = deq_pc;
    chk("count", count, n);
    chk("enq_busy", enq_busy, (n == DEPTH));
    chk("almost_full", almost_full, (n >= AF));
    chk("deq_valid", deq_valid, exp_valid);
    if (exp_valid) begin
      chk("deq_payload", {deq_instr, deq_pc, deq_excp_vld, deq_excp_code, deq_btb}, exp_b);
    end
    efire = ev && (n < DEPTH) && !fl;
    dfire = exp_valid && !db;
    @(posedge clk);
    accepted = 1'b0;
    if (rs || fl) begin
      mdl.delete();
    end else begin
      if (!(byp && dfire)) begin
        if (dfire) void'(mdl.pop_front());
        if (efire) mdl.push_back(src);
      end
      accepted = efire;
    end
    if (accepted) begin
      src     = mk(next_pc);
      next_pc = next_pc + 32'd8;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_pcs [4];
    int          got;
    int          cyc;
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_busy = 1'b0;
    load_src(32'h0);
    {enq_instr, enq_pc, enq_excp_vld, enq_excp_code, enq_btb} = src;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", obs_count, 0);
    chk("rst_busy", obs_busy, 0);
    chk("rst_valid", obs_valid, 0);
    chk("rst_af", obs_af, 0);

    // Back-to-back enqueue with a free consumer
    load_src(32'h100);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FQ_BYPASS_EN
    chk("t1_c0_pc", obs_pc, 32'h100);
`else
    chk("t1_c0_valid", obs_valid, 0);
`endif
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_c1_valid", obs_valid, 1);
`ifdef FQ_BYPASS_EN
    chk("t1_c1_pc", obs_pc, 32'h108);
`else
    chk("t1_c1_pc", obs_pc, 32'h100);
`endif
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FQ_BYPASS_EN
    chk("t1_c2_valid", obs_valid, 0);
`else
    chk("t1_c2_pc", obs_pc, 32'h108);
`endif

    // Fill while stalled, fifth bundle held by the source
    load_src(32'h200);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 2) chk("t2_af_at2", obs_af, 0);
      if (i == 3) chk("t2_af_at3", obs_af, 1);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_count_full", obs_count, 4);
    chk("t2_busy_full", obs_busy, 1);

    // Full with dequeue and offered enqueue in the same cycle
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_busy", obs_busy, 1);
    chk("t3_head", obs_pc, 32'h200);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_count", obs_count, 3);
    chk("t3_busy_low", obs_busy, 0);
    exp_pcs = '{32'h208, 32'h210, 32'h218, 32'h220};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_order", obs_pc, exp_pcs[i]);
    end

    // Flush with a concurrent enqueue offer
    load_src(32'h400);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_flush_valid", obs_valid, 0);
    chk("t4_flush_count", obs_count, 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_after_count", obs_count, 0);
    chk("t4_after_valid", obs_valid, 0);

    // Eight bundles with interleaved stalls across the pointer wrap
    load_src(32'h500);
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 200) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'b0, 1'b0);
      if (accepted) got++;
      cyc++;
    end
    chk("t5_all_enqueued", got, 8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_drained", obs_count, 0);

`ifdef FQ_BYPASS_EN
    // Same-cycle bypass on an empty queue
    load_src(32'h300);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_valid", obs_valid, 1);
    chk("t6_pc", obs_pc, 32'h300);
    chk("t6_count", obs_count, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_not_written", obs_count, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_stalled_written", obs_count, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomised soak with occasional flush and mid-operation reset
    load_src(32'h1000);
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
